// File: rtl/imm_pack_pkg.sv
// Shared EOp encodings and fit-mask type for the immediate packer.
package imm_pack_pkg;

  localparam logic [1:0] EOP_SEXT = 2'b00;
  localparam logic [1:0] EOP_ZEXT = 2'b01;
  localparam logic [1:0] EOP_LUI  = 2'b10;
  localparam logic [1:0] EOP_BR   = 2'b11;

  typedef logic [3:0] fit_t;

endpackage

// File: rtl/imm_fit.sv
// Combinational fit check: which EOp modes can reproduce v, plus the
// candidate imm for each mode.
module imm_fit
  import imm_pack_pkg::*;
(
  input  logic [31:0]      i_v,
  output fit_t             o_fit,
  output logic [3:0][15:0] o_imm
);

  logic w_hi15_eq;
  logic w_hi17_eq;

  assign w_hi15_eq = (i_v[31:15] == '0) || (i_v[31:15] == '1);
  assign w_hi17_eq = (i_v[31:17] == '0) || (i_v[31:17] == '1);

  assign o_fit[EOP_SEXT] = w_hi15_eq;
  assign o_fit[EOP_ZEXT] = (i_v[31:16] == '0);
  assign o_fit[EOP_LUI]  = (i_v[15:0] == '0);
  assign o_fit[EOP_BR]   = (i_v[1:0] == '0) && w_hi17_eq;

  assign o_imm[EOP_SEXT] = i_v[15:0];
  assign o_imm[EOP_ZEXT] = i_v[15:0];
  assign o_imm[EOP_LUI]  = i_v[31:16];
  assign o_imm[EOP_BR]   = i_v[17:2];

endmodule

// File: rtl/imm_pack.sv
// Two-stage valid/ready immediate packer (inverse of the imm extender).
// Optional per-EOp output counters under IMM_PACK_STATS_EN.
module imm_pack
  import imm_pack_pkg::*;
#(
  parameter int PRIO_LUI_FIRST = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [3:0]  in_allow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic [1:0]  out_eop,
  output logic        out_err
`ifdef IMM_PACK_STATS_EN
  ,
  output logic [4:0][15:0] stat_cnt
`endif
);

  fit_t             w_fit;
  logic [3:0][15:0] w_imm;

  logic             r_s1_valid;
  fit_t             r_s1_fit;
  logic [3:0][15:0] r_s1_imm;

  logic             r_out_valid;
  logic [15:0]      r_out_imm;
  logic [1:0]       r_out_eop;
  logic             r_out_err;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;

  logic [15:0]      w_sel_imm;
  logic [1:0]       w_sel_eop;
  logic             w_sel_err;

  imm_fit u_fit (
    .i_v   (in_value),
    .o_fit (w_fit),
    .o_imm (w_imm)
  );

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && w_s1_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_fit   <= '0;
      r_s1_imm   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_fit <= w_fit & in_allow;
        r_s1_imm <= w_imm;
      end
    end
  end

  // First allowed mode in search order wins.
  always_comb begin
    w_sel_imm = '0;
    w_sel_eop = EOP_SEXT;
    w_sel_err = 1'b0;
    if ((PRIO_LUI_FIRST != 0) && r_s1_fit[EOP_LUI]) begin
      w_sel_imm = r_s1_imm[EOP_LUI];
      w_sel_eop = EOP_LUI;
    end else if (r_s1_fit[EOP_SEXT]) begin
      w_sel_imm = r_s1_imm[EOP_SEXT];
      w_sel_eop = EOP_SEXT;
    end else if (r_s1_fit[EOP_ZEXT]) begin
      w_sel_imm = r_s1_imm[EOP_ZEXT];
      w_sel_eop = EOP_ZEXT;
    end else if (r_s1_fit[EOP_LUI]) begin
      w_sel_imm = r_s1_imm[EOP_LUI];
      w_sel_eop = EOP_LUI;
    end else if (r_s1_fit[EOP_BR]) begin
      w_sel_imm = r_s1_imm[EOP_BR];
      w_sel_eop = EOP_BR;
    end else begin
      w_sel_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_eop   <= EOP_SEXT;
      r_out_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_imm <= w_sel_imm;
        r_out_eop <= w_sel_eop;
        r_out_err <= w_sel_err;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;
  assign out_eop   = r_out_eop;
  assign out_err   = r_out_err;

`ifdef IMM_PACK_STATS_EN
  logic [4:0][15:0] r_stat;
  logic [2:0]       w_stat_idx;

  assign w_stat_idx = r_out_err ? 3'd4 : {1'b0, r_out_eop};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat <= '0;
    end else if (r_out_valid && out_ready) begin
      if (r_stat[w_stat_idx] != 16'hFFFF)
        r_stat[w_stat_idx] <= r_stat[w_stat_idx] + 16'd1;
    end
  end

  assign stat_cnt = r_stat;
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Directed-vector bench for imm_pack (default build, PRIO_LUI_FIRST=0).
module tb_imm_pack;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [3:0]  in_allow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_eop;
  logic        out_err;
`ifdef IMM_PACK_STATS_EN
  logic [4:0][15:0] stat_cnt;
`endif

  imm_pack #(.PRIO_LUI_FIRST(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_allow  (in_allow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_eop   (out_eop),
    .out_err   (out_err)
`ifdef IMM_PACK_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic [3:0]  allow;
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        err;
  } vec_t;

  vec_t tbl [14];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [15:0] imm,
                                      input logic [1:0] eop);
    case (eop)
      2'b00:   ext = {{16{imm[15]}}, imm};
      2'b01:   ext = {16'h0, imm};
      2'b10:   ext = {imm, 16'h0};
      default: ext = {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  task automatic single(input int k);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = tbl[k].value;
    in_allow = tbl[k].allow;
    #1 chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_value = 32'hDEAD_BEEF;
    in_allow = 4'b0000;
    chk($sformatf("v%0d_lat1_valid", k), 32'(out_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_valid", k), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d_imm", k), 32'(out_imm), 32'(tbl[k].imm));
    chk($sformatf("v%0d_eop", k), 32'(out_eop), 32'(tbl[k].eop));
    chk($sformatf("v%0d_err", k), 32'(out_err), 32'(tbl[k].err));
  endtask

  initial begin
    int idx_in;
    int idx_out;
    logic        prev_stall;
    logic [15:0] h_imm;
    logic [1:0]  h_eop;
    logic        h_err;

    tbl[0]  = '{32'hFFFF8000, 4'b1111, 16'h8000, 2'b00, 1'b0};
    tbl[1]  = '{32'h0000FFFF, 4'b1111, 16'hFFFF, 2'b01, 1'b0};
    tbl[2]  = '{32'h0000FFFF, 4'b0001, 16'h0000, 2'b00, 1'b1};
    tbl[3]  = '{32'h12340000, 4'b1111, 16'h1234, 2'b10, 1'b0};
    tbl[4]  = '{32'h0001FFFC, 4'b1000, 16'h7FFF, 2'b11, 1'b0};
    tbl[5]  = '{32'h12345678, 4'b1111, 16'h0000, 2'b00, 1'b1};
    tbl[6]  = '{32'h00000000, 4'b1111, 16'h0000, 2'b00, 1'b0};
    tbl[7]  = '{32'h00000000, 4'b0000, 16'h0000, 2'b00, 1'b1};
    tbl[8]  = '{32'h00000000, 4'b0100, 16'h0000, 2'b10, 1'b0};
    tbl[9]  = '{32'hFFFFFFFC, 4'b1000, 16'hFFFF, 2'b11, 1'b0};
    tbl[10] = '{32'hFFFFFFFC, 4'b1111, 16'hFFFC, 2'b00, 1'b0};
    tbl[11] = '{32'h00008000, 4'b1111, 16'h8000, 2'b01, 1'b0};
    tbl[12] = '{32'h80000000, 4'b1111, 16'h8000, 2'b10, 1'b0};
    tbl[13] = '{32'hFFFE0000, 4'b1011, 16'h8000, 2'b11, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    in_allow = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_imm", 32'(out_imm), 32'd0);
    chk("rst_out_eop", 32'(out_eop), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < 14; k++) single(k);

    // Stream 8 words back-to-back with a 3-cycle consumer stall.
    idx_in = 0;
    idx_out = 0;
    prev_stall = 1'b0;
    h_imm = '0;
    h_eop = '0;
    h_err = 1'b0;
    for (int cyc = 0; cyc < 40 && idx_out < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid = (idx_in < 8);
      in_value = tbl[idx_in % 8].value;
      in_allow = tbl[idx_in % 8].allow;
      #1;
      if (cyc == 5)
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (prev_stall && out_valid) begin
        chk("stall_imm_hold", 32'(out_imm), 32'(h_imm));
        chk("stall_eop_hold", 32'(out_eop), 32'(h_eop));
        chk("stall_err_hold", 32'(out_err), 32'(h_err));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("s%0d_imm", idx_out), 32'(out_imm),
            32'(tbl[idx_out].imm));
        chk($sformatf("s%0d_eop", idx_out), 32'(out_eop),
            32'(tbl[idx_out].eop));
        chk($sformatf("s%0d_err", idx_out), 32'(out_err),
            32'(tbl[idx_out].err));
        if (!out_err)
          chk($sformatf("s%0d_roundtrip", idx_out),
              ext(out_imm, out_eop), tbl[idx_out].value);
        idx_out++;
      end
      prev_stall = out_valid && !out_ready;
      h_imm = out_imm;
      h_eop = out_eop;
      h_err = out_err;
      if (in_valid && in_ready) idx_in++;
    end
    chk("stream_count", 32'(idx_out), 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_value = tbl[3].value;
    in_allow = tbl[3].allow;
    @(negedge clk);
    in_value = tbl[4].value;
    in_allow = tbl[4].allow;
    @(negedge clk);
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale_%0d", i), 32'(out_valid), 32'd0);
    end
    single(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
